// File: rtl/alarm_pkg.sv
// Shared state encoding and field widths for the alarm controller.
package alarm_pkg;

    localparam int STATE_W = 3;
    localparam int CD_W    = 8;

    typedef enum logic [STATE_W-1:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_e;

    // States in which a keypad code is counted as an attempt.
    function automatic logic is_secured(input state_e s);
        return (s == EXIT_DELAY) || (s == ARMED) || (s == ENTRY_DELAY) || (s == ALARM);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a registered history bit for rising-edge detection.
module sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_level,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    // Synchronizer chain plus previous-level history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {W{1'b0}};
            r_sync <= {W{1'b0}};
            r_prev <= {W{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/alarm_controller.sv
// Arming/disarming state machine driving the siren enable, with per-second
// delays, keypad code checking and failed-attempt counting.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC   = 50000000,
    parameter int unsigned N_SENSORS       = 4,
    parameter int unsigned EXIT_DELAY_S    = 10,
    parameter int unsigned ENTRY_DELAY_S   = 10,
    parameter int unsigned ALARM_TIMEOUT_S = 120,
    parameter logic [3:0]  CODE            = 4'hA,
    parameter int unsigned MAX_TRIES       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic                 arm_btn,
    input  logic [3:0]           code_in,
    input  logic                 enter_btn,
    output logic                 aux,
    output logic [STATE_W-1:0]   state,
    output logic [CD_W-1:0]      countdown,
    output logic [1:0]           tries
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [N_SENSORS-1:0] w_sens_sync;
    logic [N_SENSORS-1:0] w_sens_rise_unused;
    logic [1:0]           w_btn_level_unused;
    logic [1:0]           w_btn_rise;
    logic                 w_arm_rise;
    logic                 w_enter_rise;

    state_e               r_state;
    state_e               w_next_state;
    logic [CD_W-1:0]      r_countdown;
    logic [CD_W-1:0]      w_countdown_nxt;
    logic [1:0]           r_tries;
    logic [1:0]           w_tries_nxt;
    logic [1:0]           w_tries_inc;
    logic                 r_aux;
    logic [PW-1:0]        r_presc;

    logic                 w_tick;
    logic                 w_change;
    logic                 w_valid;
    logic                 w_wrong;
    logic                 w_force;
    logic                 w_expire;
    logic                 w_any_open;

    sync_edge #(.W(N_SENSORS)) u_sync_sensor (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (sensor),
        .o_level (w_sens_sync),
        .o_rise  (w_sens_rise_unused)
    );

    sync_edge #(.W(2)) u_sync_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     ({enter_btn, arm_btn}),
        .o_level (w_btn_level_unused),
        .o_rise  (w_btn_rise)
    );

    assign w_arm_rise   = w_btn_rise[0];
    assign w_enter_rise = w_btn_rise[1];

    function automatic logic [CD_W-1:0] delay_for(input state_e s);
        case (s)
            EXIT_DELAY:  return CD_W'(EXIT_DELAY_S);
            ENTRY_DELAY: return CD_W'(ENTRY_DELAY_S);
            ALARM:       return CD_W'(ALARM_TIMEOUT_S);
            default:     return {CD_W{1'b0}};
        endcase
    endfunction

    assign w_tick      = (r_presc == PW'(TICKS_PER_SEC - 1));
    assign w_valid     = w_enter_rise && (code_in == CODE);
    assign w_wrong     = w_enter_rise && (code_in != CODE);
    assign w_expire    = w_tick && (r_countdown == CD_W'(1));
    assign w_any_open  = |w_sens_sync;
    // A wrong code that completes the allowed attempts forces the siren.
    assign w_force     = w_wrong && (r_tries >= 2'(MAX_TRIES - 1));
    assign w_tries_inc = (r_tries == 2'(MAX_TRIES)) ? r_tries : r_tries + 2'd1;
    assign w_change    = (w_next_state != r_state);

    // Next-state selection in priority order: valid, forcing, trip, expiry, arm.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DISARMED: begin
                if (w_arm_rise && !w_any_open) w_next_state = EXIT_DELAY;
                else                           w_next_state = DISARMED;
            end
            EXIT_DELAY: begin
                if (w_valid)       w_next_state = DISARMED;
                else if (w_force)  w_next_state = ALARM;
                else if (w_expire) w_next_state = ARMED;
                else               w_next_state = EXIT_DELAY;
            end
            ARMED: begin
                if (w_valid)         w_next_state = DISARMED;
                else if (w_force)    w_next_state = ALARM;
                else if (w_any_open) w_next_state = ENTRY_DELAY;
                else                 w_next_state = ARMED;
            end
            ENTRY_DELAY: begin
                if (w_valid)       w_next_state = DISARMED;
                else if (w_force)  w_next_state = ALARM;
                else if (w_expire) w_next_state = ALARM;
                else               w_next_state = ENTRY_DELAY;
            end
            ALARM: begin
                if (w_valid)       w_next_state = DISARMED;
                else if (w_expire) w_next_state = ARMED;
                else               w_next_state = ALARM;
            end
            default: w_next_state = DISARMED;
        endcase
    end

    // Attempt counter and countdown updates.
    always_comb begin
        w_tries_nxt     = r_tries;
        w_countdown_nxt = r_countdown;
        if (w_next_state == DISARMED) begin
            w_tries_nxt = 2'd0;
        end else if ((r_state == ALARM) && (w_next_state == ARMED)) begin
            w_tries_nxt = 2'd0;
        end else if (w_wrong && is_secured(r_state)) begin
            w_tries_nxt = w_tries_inc;
        end else begin
            w_tries_nxt = r_tries;
        end
        if (w_change) begin
            w_countdown_nxt = delay_for(w_next_state);
        end else if (w_tick && (r_countdown != {CD_W{1'b0}})) begin
            w_countdown_nxt = r_countdown - CD_W'(1);
        end else begin
            w_countdown_nxt = r_countdown;
        end
    end

    // State, status and siren registers; prescaler restarts on each state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DISARMED;
            r_aux       <= 1'b0;
            r_countdown <= {CD_W{1'b0}};
            r_tries     <= 2'd0;
            r_presc     <= {PW{1'b0}};
        end else begin
            r_state     <= w_next_state;
            r_aux       <= (w_next_state == ALARM);
            r_countdown <= w_countdown_nxt;
            r_tries     <= w_tries_nxt;
            if (w_change || w_tick) r_presc <= {PW{1'b0}};
            else                    r_presc <= r_presc + PW'(1);
        end
    end

    assign state     = r_state;
    assign aux       = r_aux;
    assign countdown = r_countdown;
    assign tries     = r_tries;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random stimulus, all
// checked every cycle against a seconds/elapsed-cycle reference model.
module tb_alarm_controller;

    localparam int          T      = 4;
    localparam int          EXIT_S = 3;
    localparam int          ENTR_S = 2;
    localparam int          TO_S   = 5;
    localparam int          MAXT   = 3;
    localparam logic [3:0]  CODE   = 4'hA;

    localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sensor = 4'd0;
    logic       arm_btn = 1'b0;
    logic [3:0] code_in = 4'd0;
    logic       enter_btn = 1'b0;
    logic       aux;
    logic [2:0] state;
    logic [7:0] countdown;
    logic [1:0] tries;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state, attempts, cycles spent in current state, and
    // input history (index 1 = sampled one edge ago, etc.).
    int   m_state, m_tries, m_cyc, m_cd;
    bit   a1, a2, a3, e1, e2, e3;
    logic [3:0] s1, s2;

    alarm_controller #(
        .TICKS_PER_SEC(T), .N_SENSORS(4), .EXIT_DELAY_S(EXIT_S),
        .ENTRY_DELAY_S(ENTR_S), .ALARM_TIMEOUT_S(TO_S), .CODE(CODE), .MAX_TRIES(MAXT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor(sensor), .arm_btn(arm_btn),
        .code_in(code_in), .enter_btn(enter_btn), .aux(aux), .state(state),
        .countdown(countdown), .tries(tries)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int secs_of(input int st);
        if (st == M_EXIT)  return EXIT_S;
        if (st == M_ENTRY) return ENTR_S;
        if (st == M_ALARM) return TO_S;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = M_DIS; m_tries = 0; m_cyc = 0; m_cd = 0;
        a1 = 0; a2 = 0; a3 = 0; e1 = 0; e2 = 0; e3 = 0; s1 = 0; s2 = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        bit arm_p, ent_p, valid, wrong, expire;
        int nxt, nt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        arm_p  = a2 && !a3;
        ent_p  = e2 && !e3;
        valid  = ent_p && (code_in == CODE);
        wrong  = ent_p && (code_in != CODE);
        expire = (secs_of(m_state) > 0) && (m_cyc + 1 == secs_of(m_state) * T);
        nxt = m_state;
        nt  = m_tries;
        if (m_state == M_DIS) begin
            if (arm_p && s2 == 4'd0) nxt = M_EXIT;
        end else if (valid) begin
            nxt = M_DIS;
        end else begin
            if (wrong) nt = (m_tries + 1 > MAXT) ? MAXT : m_tries + 1;
            if (wrong && nt == MAXT && m_state != M_ALARM) nxt = M_ALARM;
            else if (m_state == M_ARMED && s2 != 4'd0)     nxt = M_ENTRY;
            else if (expire) nxt = (m_state == M_ENTRY) ? M_ALARM : M_ARMED;
        end
        if (nxt == M_DIS) nt = 0;
        if (m_state == M_ALARM && nxt == M_ARMED) nt = 0;
        m_cyc   = (nxt != m_state) ? 0 : m_cyc + 1;
        m_state = nxt;
        m_tries = nt;
        m_cd    = (secs_of(nxt) > 0) ? secs_of(nxt) - m_cyc / T : 0;
        a3 = a2; a2 = a1; a1 = arm_btn;
        e3 = e2; e2 = e1; e1 = enter_btn;
        s2 = s1; s1 = sensor;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("state", int'(state), m_state);
        check_eq("countdown", int'(countdown), m_cd);
        check_eq("tries", int'(tries), m_tries);
        check_eq("aux", int'(aux), (m_state == M_ALARM) ? 1 : 0);
    endtask

    task automatic press_arm(input int hold);
        arm_btn = 1'b1;
        repeat (hold) step();
        arm_btn = 1'b0;
        step();
    endtask

    task automatic press_enter(input logic [3:0] c, input int hold);
        code_in = c;
        enter_btn = 1'b1;
        repeat (hold) step();
        enter_btn = 1'b0;
        step();
    endtask

    task automatic wait_state(input int st, input int budget);
        int n = 0;
        while (int'(state) != st && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_state", int'(state), st);
    endtask

    // From ARMED with no attempts: two wrong codes, then a third whose edge
    // enters ALARM exactly when this task returns.
    task automatic force_alarm();
        press_enter(4'h3, 2);
        check_eq("tries_1", int'(tries), 1);
        press_enter(4'h3, 2);
        check_eq("tries_2", int'(tries), 2);
        code_in = 4'h3;
        enter_btn = 1'b1;
        step(); step(); step();
        enter_btn = 1'b0;
        check_eq("forced_state", int'(state), M_ALARM);
        check_eq("forced_aux", int'(aux), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) step();
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_aux", int'(aux), 0);
        check_eq("rst_cd", int'(countdown), 0);
        rst_n = 1'b1;
        repeat (3) step();

        // Arm with all zones closed: exit delay 3-2-1 then ARMED after 12 cycles.
        arm_btn = 1'b1;
        step(); step();
        check_eq("arm_latency_pre", int'(state), M_DIS);
        step();
        arm_btn = 1'b0;
        check_eq("exit_state", int'(state), M_EXIT);
        check_eq("exit_cd3", int'(countdown), 3);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 4)  check_eq("exit_cd2", int'(countdown), 2);
            if (i == 8)  check_eq("exit_cd1", int'(countdown), 1);
            if (i == 11) check_eq("exit_hold", int'(state), M_EXIT);
            check_eq("exit_aux", int'(aux), 0);
        end
        check_eq("armed_state", int'(state), M_ARMED);

        // Zone trip: entry delay 2 s then ALARM; valid code disarms.
        sensor = 4'b0100;
        step(); step(); step();
        check_eq("entry_state", int'(state), M_ENTRY);
        check_eq("entry_cd", int'(countdown), 2);
        repeat (7) step();
        check_eq("entry_hold", int'(state), M_ENTRY);
        step();
        check_eq("alarm_state", int'(state), M_ALARM);
        check_eq("alarm_aux", int'(aux), 1);
        sensor = 4'b0000;
        press_enter(CODE, 2);
        check_eq("disarm_state", int'(state), M_DIS);
        check_eq("disarm_aux", int'(aux), 0);
        check_eq("disarm_tries", int'(tries), 0);

        // Arm ignored with an open zone, accepted once closed.
        sensor = 4'b0001;
        repeat (3) step();
        press_arm(2);
        check_eq("arm_open_ignored", int'(state), M_DIS);
        sensor = 4'b0000;
        repeat (3) step();
        press_arm(2);
        check_eq("arm_closed", int'(state), M_EXIT);
        wait_state(M_ARMED, 20);

        // A long hold counts as a single attempt.
        press_enter(4'h3, 20);
        check_eq("hold_once", int'(tries), 1);
        press_enter(4'h3, 2);
        check_eq("tries_two", int'(tries), 2);
        press_enter(4'h3, 2);
        check_eq("third_wrong", int'(state), M_ALARM);
        check_eq("third_aux", int'(aux), 1);
        check_eq("third_tries", int'(tries), MAXT);
        press_enter(4'h5, 2);
        check_eq("tries_sat", int'(tries), MAXT);
        wait_state(M_ARMED, 40);

        // ALARM times out to ARMED exactly 20 cycles after entry.
        force_alarm();
        repeat (19) step();
        check_eq("timeout_hold", int'(state), M_ALARM);
        check_eq("timeout_cd", int'(countdown), 1);
        step();
        check_eq("timeout_state", int'(state), M_ARMED);
        check_eq("timeout_aux", int'(aux), 0);
        check_eq("timeout_tries", int'(tries), 0);

        // Valid code on the expiry edge wins over re-arm.
        force_alarm();
        repeat (17) step();
        code_in = CODE;
        enter_btn = 1'b1;
        step(); step(); step();
        enter_btn = 1'b0;
        check_eq("code_beats_expiry", int'(state), M_DIS);
        check_eq("code_beats_aux", int'(aux), 0);

        // Asynchronous reset between edges during ALARM.
        press_arm(2);
        wait_state(M_ARMED, 20);
        force_alarm();
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_state", int'(state), 0);
        check_eq("arst_aux", int'(aux), 0);
        check_eq("arst_cd", int'(countdown), 0);
        check_eq("arst_tries", int'(tries), 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        check_eq("arst_release", int'(state), M_DIS);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            if (enter_btn) begin
                if ($urandom_range(2, 0) == 0) enter_btn = 1'b0;
            end else if ($urandom_range(11, 0) == 0) begin
                code_in = ($urandom_range(1, 0) == 0) ? CODE : 4'($urandom_range(15, 0));
                enter_btn = 1'b1;
            end
            if (arm_btn) begin
                if ($urandom_range(2, 0) == 0) arm_btn = 1'b0;
            end else if ($urandom_range(9, 0) == 0) begin
                arm_btn = 1'b1;
            end
            if ($urandom_range(24, 0) == 0) sensor[$urandom_range(3, 0)] ^= 1'b1;
            if ($urandom_range(14, 0) == 0) sensor = 4'd0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Upstream control stage of the alarm system.
- Debounce-free, synchronized arming/disarming state machine that watches door/window sensors and a 4-bit code keypad.
- Drives the single-bit siren enable `aux` consumed by the buzzer stage. `aux=0` gives a silent constant speaker level; `aux=1` gives the sweeping tone.
- Also exports state, countdown and failed-attempt status for LEDs/7-segment.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second tick.
- N_SENSORS, 4, number of sensor inputs.
- EXIT_DELAY_S, 10, seconds from arm to ARMED (1..255).
- ENTRY_DELAY_S, 10, seconds from sensor trip to ALARM (1..255).
- ALARM_TIMEOUT_S, 120, seconds of siren before auto re-arm (1..255).
- CODE, 4'hA, valid disarm code.
- MAX_TRIES, 3, wrong codes that force ALARM (1..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sensor  in  N_SENSORS  1 = zone open/tripped; asynchronous
- arm_btn  in  1  arm request, level from button; asynchronous
- code_in  in  4  keypad/switch code; sampled on enter
- enter_btn  in  1  code submit, level from button; asynchronous
- aux  out  1  siren enable to buzzer stage; registered
- state  out  3  current state encoding
- countdown  out  8  remaining seconds of active delay/timeout, else 0
- tries  out  2  wrong-code count

Behaviour:
- Reset (async, rst_n=0): state=DISARMED, aux=0, countdown=0, tries=0, prescaler=0, all sync flops=0. Takes effect immediately, including mid-delay or mid-ALARM.
- Input sync: sensor, arm_btn, enter_btn each pass through 2 flops. Buttons get rising-edge detect (one-cycle pulse).
  - A button first sampled high at edge k updates state/aux at edge k+2.
  - Holding a button gives one pulse only.
  - code_in is sampled, unsynchronized, on the enter pulse cycle. It is stable while enter is pressed.
- Prescaler: counts 0..TICKS_PER_SEC-1, with a one-cycle tick at the terminal count. It clears on every state change, so every delay is exactly N full seconds.
- countdown: loaded with the delay on entry to EXIT_DELAY/ENTRY_DELAY/ALARM and decremented on each tick. Expiry is the tick where countdown goes 1->0. It is 0 in DISARMED/ARMED.
- Valid = enter pulse and code_in==CODE. Wrong = enter pulse and code_in!=CODE.
- States and transitions:
  - DISARMED (0): arm pulse with all sensors closed -> EXIT_DELAY. Arm with any sensor open is ignored. Enter is ignored.
  - EXIT_DELAY (1): valid -> DISARMED; expiry -> ARMED. Sensors are ignored.
  - ARMED (2): valid -> DISARMED; any synced sensor high -> ENTRY_DELAY.
  - ENTRY_DELAY (3): valid -> DISARMED; expiry -> ALARM.
  - ALARM (4): aux=1. Valid -> DISARMED; expiry -> ARMED. If a sensor is still open, the next cycle goes to ENTRY_DELAY.
- Wrong code in states 1-4: tries++. If tries reaches MAX_TRIES outside ALARM -> ALARM immediately. In ALARM, tries saturates at MAX_TRIES.
- tries clears on entry to DISARMED and on ALARM->ARMED.
- Priority in one cycle: valid code > wrong-code forcing > sensor trip > expiry > arm.
- aux is registered from next_state==ALARM, so it changes on the same edge as state.
- Encodings 5-7 are illegal: they go to DISARMED on the next edge with aux=0.

Decomposition:
- alarm_pkg: state localparams (DISARMED=3'd0, EXIT_DELAY=3'd1, ARMED=3'd2, ENTRY_DELAY=3'd3, ALARM=3'd4), state width 3, countdown width 8.
- Sub-module sync_edge (2-flop synchronizer, outputs sync level and rise pulse, async active-low reset). Used for arm_btn, enter_btn and each sensor bit (level output).

Test Plan (TICKS_PER_SEC=4, EXIT=3, ENTRY=2, TIMEOUT=5, CODE=4'hA, MAX_TRIES=3):
- Sensors 0, arm pulse -> state 1 at edge k+2, countdown 3->2->1; state 2 exactly 12 cycles later; aux stays 0.
- Sensor[0]=1, arm pulse -> state remains 0. Clear sensor, arm again -> state 1.
- In ARMED set sensor[2]=1 -> state 3 with countdown 2; no code -> state 4 after 8 cycles with aux=1. Then code_in=4'hA + enter -> state 0, aux=0, tries=0.
- In ARMED enter 4'h3 three times -> tries 1, 2, then state 4 and aux=1 on the third pulse. Holding enter high 20 cycles counts once.
- ALARM with no input -> state 2, aux=0 after 20 cycles. Valid code pulse landing on the expiry tick -> state 0, since code wins.
- rst_n low mid-ALARM, asynchronously between edges -> aux=0, state 0, countdown 0 immediately. Release -> stays DISARMED.
